alu_serial_rx: RTL

//  Parametrised receive front-end for the serial ALU protocol: deserialises sin frames into operands B, A and

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_crc4.sv | 32 +++
 rtl/alu_serial_rx.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the serial ALU receive and response paths.
//   operation_t  - supported ALU opcodes
//   ERR_*        - bit positions inside the 3-bit error vector {DATA, CRC, OP}
//   FRAME_LEN    - serial frame length in bits (start, type, 8 payload, stop)
//   CRC4_POLY    - low terms of x^4+x+1
//   crc4_next()  - one MSB-first serial step of the CRC-4 LFSR
//   op_supported() - opcode legality check
//   frame_state_t  - receive frame FSM states
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    localparam int unsigned FRAME_LEN = 11;

    localparam logic [3:0] CRC4_POLY = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TYPE,
        ST_PAYLOAD,
        ST_STOP
    } frame_state_t;

    function automatic logic [3:0] crc4_next(input logic [3:0] crc, input logic din);
        logic fb;
        fb = crc[3] ^ din;
        return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    endfunction

    function automatic logic op_supported(input logic [2:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_crc4.sv
// alu_crc4: serial CRC-4 (x^4+x+1, init 0, MSB first) with synchronous clear.
//   clk, rst - clock, asynchronous active-high reset
//   i_clr    - restart the CRC at 0 (wins over i_en)
//   i_en     - advance the LFSR by one bit
//   i_bit    - serial data bit
//   o_crc    - current remainder
module alu_crc4
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [3:0] o_crc
);

    logic [3:0] r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= '0;
        end else if (i_clr) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= crc4_next(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: serial ALU packet receiver.
// Deserialises 11-bit frames from sin into operands B, A and opcode, checks
// framing, frame count, CRC-4 and opcode, and presents one result per packet
// on a valid/ready output register.
//   clk, rst   - clock, asynchronous active-high reset
//   sin        - serial input, idle high, one bit per cycle
//   out_valid  - result available; out_ready accepts it
//   out_b/a    - operands (B received first)
//   out_op     - opcode
//   out_err    - {ERR_DATA, ERR_CRC, ERR_OP}, at most one bit set
//   overrun    - one-cycle pulse when a finished packet is dropped
module alu_serial_rx
    import alu_pkg::*;
#(
    parameter int unsigned N_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYC = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*N_BYTES-1:0] out_b,
    output logic [8*N_BYTES-1:0] out_a,
    output logic [2:0]           out_op,
    output logic [2:0]           out_err,
    output logic                 overrun
);

    localparam int unsigned DATA_W   = 8 * N_BYTES;
    localparam int unsigned N_FRAMES = 2 * N_BYTES;
    localparam int unsigned FCNT_W   = $clog2(N_FRAMES + 2);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYC);
    localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(N_FRAMES);
    localparam logic [FCNT_W-1:0] FCNT_SAT  = FCNT_W'(N_FRAMES + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    frame_state_t        r_state;
    logic                r_is_cmd;
    logic [2:0]          r_bit_cnt;
    logic [FCNT_W-1:0]   r_fcnt;
    logic [TO_W-1:0]     r_idle_cnt;
    logic                r_pkt_open;
    logic                r_err_data;
    logic [2*DATA_W-1:0] r_shift;
    logic [2:0]          r_op;
    logic [3:0]          r_rx_crc;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_b;
    logic [DATA_W-1:0]   r_out_a;
    logic [2:0]          r_out_op;
    logic [2:0]          r_out_err;
    logic                r_overrun;

    logic                w_cmd_done;
    logic                w_timeout;
    logic                w_done;
    logic                w_crc_en;
    logic                w_crc_bit;
    logic [3:0]          w_crc;
    logic                w_err_data;
    logic [DATA_W-1:0]   w_res_b;
    logic [DATA_W-1:0]   w_res_a;
    logic [2:0]          w_res_op;
    logic [2:0]          w_res_err;

    always_comb begin
        w_cmd_done = (r_state == ST_STOP) && r_is_cmd;
        w_timeout  = (r_state == ST_IDLE) && sin && r_pkt_open && (r_idle_cnt == TO_LAST);
        w_done     = w_cmd_done || w_timeout;
        // Cmd payload: bit7 is replaced by a constant 1, OP bits are fed,
        // the received CRC nibble (bits 3..0) is not.
        w_crc_en   = (r_state == ST_PAYLOAD) && (!r_is_cmd || (r_bit_cnt >= 3'd4));
        w_crc_bit  = (r_is_cmd && (r_bit_cnt == 3'd7)) ? 1'b1 : sin;
        // sin here is the cmd-frame stop bit
        w_err_data = r_err_data || !sin || (r_fcnt != FCNT_FULL);
        w_res_b    = '0;
        w_res_a    = '0;
        w_res_op   = '0;
        w_res_err  = '0;
        if (w_timeout) begin
            w_res_err[ERR_DATA] = 1'b1;
        end else begin
            w_res_b  = r_shift[2*DATA_W-1:DATA_W];
            w_res_a  = r_shift[DATA_W-1:0];
            w_res_op = r_op;
            if (w_err_data) begin
                w_res_err[ERR_DATA] = 1'b1;
            end else if (w_crc != r_rx_crc) begin
                w_res_err[ERR_CRC] = 1'b1;
            end else if (!op_supported(r_op)) begin
                w_res_err[ERR_OP] = 1'b1;
            end
        end
    end

    alu_crc4 u_crc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_done),
        .i_en  (w_crc_en),
        .i_bit (w_crc_bit),
        .o_crc (w_crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_is_cmd    <= 1'b0;
            r_bit_cnt   <= '0;
            r_fcnt      <= '0;
            r_idle_cnt  <= '0;
            r_pkt_open  <= 1'b0;
            r_err_data  <= 1'b0;
            r_shift     <= '0;
            r_op        <= '0;
            r_rx_crc    <= '0;
            r_out_valid <= 1'b0;
            r_out_b     <= '0;
            r_out_a     <= '0;
            r_out_op    <= '0;
            r_out_err   <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;

            // Output register: a completion loads when the slot is free or
            // is being emptied this cycle; otherwise it is dropped.
            if (w_done) begin
                if (!r_out_valid || out_ready) begin
                    r_out_valid <= 1'b1;
                    r_out_b     <= w_res_b;
                    r_out_a     <= w_res_a;
                    r_out_op    <= w_res_op;
                    r_out_err   <= w_res_err;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!sin) begin
                        r_state    <= ST_TYPE;
                        r_idle_cnt <= '0;
                    end else if (w_timeout) begin
                        r_pkt_open <= 1'b0;
                        r_fcnt     <= '0;
                        r_err_data <= 1'b0;
                        r_shift    <= '0;
                        r_idle_cnt <= '0;
                    end else if (r_pkt_open) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                ST_TYPE: begin
                    r_is_cmd  <= sin;
                    r_bit_cnt <= 3'd7;
                    r_state   <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (!r_is_cmd) begin
                        r_shift <= {r_shift[2*DATA_W-2:0], sin};
                    end else if (r_bit_cnt >= 3'd4) begin
                        if (r_bit_cnt != 3'd7) begin
                            r_op <= {r_op[1:0], sin};
                        end
                    end else begin
                        r_rx_crc <= {r_rx_crc[2:0], sin};
                    end
                    if (r_bit_cnt == 3'd0) begin
                        r_state <= ST_STOP;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    r_state <= ST_IDLE;
                    if (r_is_cmd) begin
                        r_pkt_open <= 1'b0;
                        r_fcnt     <= '0;
                        r_err_data <= 1'b0;
                        r_shift    <= '0;
                    end else begin
                        r_pkt_open <= 1'b1;
                        if (!sin) begin
                            r_err_data <= 1'b1;
                        end
                        if (r_fcnt != FCNT_SAT) begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_b     = r_out_b;
    assign out_a     = r_out_a;
    assign out_op    = r_out_op;
    assign out_err   = r_out_err;
    assign overrun   = r_overrun;

endmodule
